imem_boot_loader: RTL and testbench

//  Upstream of riscv_core_with_mem: fills instruction memory from a framed byte stream, holds core in reset until done.

---
 rtl/imem_boot_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a framed byte stream into instruction-memory writes and releases core reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t TAIL_STATE = ST_CSUM;
`else
    localparam state_t TAIL_STATE = ST_DONE;
`endif

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t      state_r;
    logic [15:0] count_r;
    logic [15:0] word_idx_r;
    logic [1:0]  byte_idx_r;
    logic [23:0] word_buf_r;
    logic [7:0]  csum_r;
    logic        last_wr_r;

    logic        accept_s;
    logic [15:0] len_s;

    // Handshake qualifier and the full word count as seen during the high length byte
    always_comb begin
        accept_s = rx_valid && rx_ready;
        len_s    = {rx_data, count_r[7:0]};
    end

    // Frame parser FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rx_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0000_0000;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            count_r    <= 16'h0000;
            word_idx_r <= 16'h0000;
            byte_idx_r <= 2'd0;
            word_buf_r <= 24'h00_0000;
            csum_r     <= 8'h00;
            last_wr_r  <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (rx_data == SYNC_BYTE)) begin
                        state_r <= ST_LEN_LO;
                        csum_r  <= 8'h00;
                    end
                end
                ST_LEN_LO: begin
                    if (accept_s) begin
                        count_r[7:0] <= rx_data;
                        state_r      <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept_s) begin
                        count_r[15:8] <= rx_data;
                        word_idx_r    <= 16'h0000;
                        byte_idx_r    <= 2'd0;
                        if ({1'b0, len_s} > MAX_WORDS) begin
                            state_r  <= ST_ERR;
                            rx_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else if (len_s == 16'h0000) begin
                            state_r    <= TAIL_STATE;
                            rx_ready   <= (TAIL_STATE != ST_DONE);
                            load_done  <= (TAIL_STATE == ST_DONE);
                            core_reset <= (TAIL_STATE != ST_DONE);
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // The final word's write cycle stalls the stream so no byte slips in before the tail
                    if (last_wr_r) begin
                        last_wr_r  <= 1'b0;
                        state_r    <= TAIL_STATE;
                        rx_ready   <= (TAIL_STATE != ST_DONE);
                        load_done  <= (TAIL_STATE == ST_DONE);
                        core_reset <= (TAIL_STATE != ST_DONE);
                    end else if (accept_s) begin
                        csum_r <= csum_fold(csum_r, rx_data);
                        if (byte_idx_r == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx_r[ADDR_WIDTH-1:0];
                            imem_wdata <= {rx_data, word_buf_r};
                            word_idx_r <= word_idx_r + 16'd1;
                            byte_idx_r <= 2'd0;
                            if ((word_idx_r + 16'd1) == count_r) begin
                                last_wr_r <= 1'b1;
                                rx_ready  <= 1'b0;
                            end
                        end else begin
                            word_buf_r <= {rx_data, word_buf_r[23:8]};
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept_s) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum_r) begin
                            state_r    <= ST_DONE;
                            load_done  <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state_r  <= ST_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    rx_ready <= 1'b0;
                end
                ST_ERR: begin
                    rx_ready <= 1'b0;
                end
                default: begin
                    state_r  <= ST_ERR;
                    rx_ready <= 1'b0;
                    load_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frame table, reset-mid-frame sequence, random frames.
module tb_imem_boot_loader;

    localparam int ST_PEND = 0;
    localparam int ST_OK   = 1;
    localparam int ST_BAD  = 2;
`ifdef LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct {
        string        name;
        logic [127:0] bits;
        int           len;
        int           st;
        int           nw;
        logic [31:0]  w0;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        load_done;
    logic        load_err;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [39:0] obs_q[$];
    logic [31:0] mem_model[256];
    logic        prev_we = 1'b0;
    logic [31:0] exp_words[$];
    int          exp_status;

    imem_boot_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset(core_reset),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Write monitor: records every strobe and flags strobes longer than one cycle
    always @(negedge clk) begin
        if (imem_we) begin
            obs_q.push_back({imem_addr, imem_wdata});
            mem_model[imem_addr] = imem_wdata;
            check("we_single_cycle", {39'd0, prev_we}, 40'd0);
        end
        prev_we = imem_we;
    end

    // Reference frame decoder: works from the byte list alone
    function automatic void ref_model(input bq_t fb);
        int i;
        int cnt;
        logic [7:0] x;
        i = 0;
        x = 8'h00;
        exp_words.delete();
        exp_status = ST_PEND;
        while (i < fb.size() && fb[i] != 8'hA5) i++;
        i++;
        if (i + 2 > fb.size()) return;
        cnt = int'(fb[i]) + 256 * int'(fb[i+1]);
        i += 2;
        if (cnt > 256) begin
            exp_status = ST_BAD;
            return;
        end
        for (int w = 0; w < cnt; w++) begin
            if (i + 4 > fb.size()) return;
            exp_words.push_back({fb[i+3], fb[i+2], fb[i+1], fb[i]});
            x = x ^ fb[i] ^ fb[i+1] ^ fb[i+2] ^ fb[i+3];
            i += 4;
        end
        if (CS == 1) begin
            if (i >= fb.size()) return;
            exp_status = (fb[i] == x) ? ST_OK : ST_BAD;
        end else begin
            exp_status = ST_OK;
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Offers one byte after a random idle gap; returns at the negedge following acceptance
    task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        ok = 1'b0;
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            rx_data = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data = b;
        for (int t = 0; t < 50; t++) begin
            if (rx_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (!ok) rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string nm, input bq_t fb, input int max_gap, input bit do_rst,
                             input int hand_st, input int hand_nw, input logic [31:0] hand_w0);
        bit ok;
        if (do_rst) do_reset();
        obs_q.delete();
        foreach (fb[k]) begin
            send_byte(fb[k], max_gap, ok);
            if (!ok) begin
                check({nm, " byte_accept_timeout"}, 40'd0, 40'd1);
                break;
            end
        end
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        ref_model(fb);
        check({nm, " load_done"},  {39'd0, load_done},  {39'd0, exp_status == ST_OK});
        check({nm, " load_err"},   {39'd0, load_err},   {39'd0, exp_status == ST_BAD});
        check({nm, " core_reset"}, {39'd0, core_reset}, {39'd0, exp_status != ST_OK});
        check({nm, " rx_ready"},   {39'd0, rx_ready},   {39'd0, exp_status == ST_PEND});
        check({nm, " write_count"}, 40'(obs_q.size()), 40'(exp_words.size()));
        for (int k = 0; k < exp_words.size() && k < obs_q.size(); k++)
            check({nm, " write"}, obs_q[k], {8'(k), exp_words[k]});
        if (hand_st >= 0) begin
            check({nm, " hand_status"}, {38'd0, load_err, load_done},
                  (hand_st == ST_OK) ? 40'd1 : 40'd2);
            check({nm, " hand_count"}, 40'(obs_q.size()), 40'(hand_nw));
            if (hand_nw > 0 && obs_q.size() > 0)
                check({nm, " hand_word0"}, obs_q[0], {8'd0, hand_w0});
        end
    endtask

    initial begin
        vec_t        vecs[$];
        bq_t         fq;
        logic [31:0] w[4];
        logic [7:0]  x;
        bit          ok;

        vecs.push_back('{"basic2", 128'hA5020013_051000B3_05B50005_00000000, 11 + CS, ST_OK, 2, 32'h0010_0513});
        vecs.push_back('{"stray",  128'h00FFA501_00EFBEAD_DE220000_00000000, 9 + CS,  ST_OK, 1, 32'hDEAD_BEEF});
        vecs.push_back('{"oversize", 128'hA5010100_00000000_00000000_00000000, 3,     ST_BAD, 0, 32'h0});
        vecs.push_back('{"count0", 128'hA5000000_00000000_00000000_00000000, 3 + CS,  ST_OK, 0, 32'h0});
        vecs.push_back('{"sync_in_data", 128'hA50100A5_A5A5A500_00000000_00000000, 7 + CS, ST_OK, 1, 32'hA5A5_A5A5});
        if (CS == 1)
            vecs.push_back('{"bad_csum", 128'hA50100EF_BEADDE23_00000000_00000000, 8, ST_BAD, 1, 32'hDEAD_BEEF});

        // Reset values
        repeat (2) @(negedge clk);
        check("rst core_reset", {39'd0, core_reset}, 40'd1);
        check("rst rx_ready",   {39'd0, rx_ready},   40'd1);
        check("rst imem_we",    {39'd0, imem_we},    40'd0);
        check("rst load_done",  {39'd0, load_done},  40'd0);
        check("rst load_err",   {39'd0, load_err},   40'd0);
        check("rst addr_data",  {imem_addr, imem_wdata}, 40'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[v]) begin
            fq.delete();
            for (int k = 0; k < vecs[v].len; k++) fq.push_back(vecs[v].bits[127 - 8*k -: 8]);
            run_frame(vecs[v].name, fq, (v % 2) * 3, 1'b1, vecs[v].st, vecs[v].nw, vecs[v].w0);
        end

        // Reset after two of four words, then a full resend
        foreach (w[k]) w[k] = $urandom;
        fq.delete();
        fq.push_back(8'hA5); fq.push_back(8'h04); fq.push_back(8'h00);
        x = 8'h00;
        for (int k = 0; k < 16; k++) begin
            fq.push_back(w[k/4][8*(k%4) +: 8]);
            x = x ^ w[k/4][8*(k%4) +: 8];
        end
        if (CS == 1) fq.push_back(x);
        do_reset();
        obs_q.delete();
        for (int k = 0; k < 11; k++) send_byte(fq[k], 3, ok);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst writes_before", 40'(obs_q.size()), 40'd2);
        #2 reset = 1'b1;
        #1;
        check("midrst core_reset", {39'd0, core_reset}, 40'd1);
        check("midrst rx_ready",   {39'd0, rx_ready},   40'd1);
        check("midrst imem_addr",  {32'd0, imem_addr},  40'd0);
        check("midrst done_err",   {38'd0, load_err, load_done}, 40'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame("resend", fq, 4, 1'b0, ST_OK, 4, w[0]);
        for (int k = 0; k < 4; k++) check("resend mem", {8'(k), mem_model[k]}, {8'(k), w[k]});
        #2 reset = 1'b1;
        #1 check("done_then_reset core_reset", {39'd0, core_reset}, 40'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Random frames with strays, gaps and occasional corruption
        for (int r = 0; r < 10; r++) begin
            int cnt;
            logic [7:0] b;
            fq.delete();
            for (int s = $urandom_range(2, 0); s > 0; s--) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                fq.push_back(b);
            end
            cnt = (r == 9) ? int'($urandom_range(65535, 257)) : int'($urandom_range(8, 1));
            fq.push_back(8'hA5); fq.push_back(8'(cnt)); fq.push_back(8'(cnt >> 8));
            if (cnt <= 256) begin
                x = 8'h00;
                for (int k = 0; k < 4 * cnt; k++) begin
                    b = 8'($urandom);
                    fq.push_back(b);
                    x = x ^ b;
                end
                if (CS == 1) fq.push_back(($urandom_range(3, 0) == 0) ? ~x : x);
            end
            run_frame("random", fq, 3, 1'b1, -1, 0, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
